// File: rtl/reaction_core.sv
// reaction_core: reaction-time tester core.
// Random hold-off, millisecond BCD count, foul and timeout handling.

module reaction_core #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] bcd3,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       led_go,
  output logic       foul,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_FOUL
  } state_t;

  localparam logic [15:0] TICK_LAST =
    16'(TICK_DIV - 1);

  localparam logic [11:0] DLY_BASE =
    12'd1024;

  state_t state;
  state_t state_n;

  logic start_q;
  logic stop_q;
  logic start_rise;
  logic stop_rise;

  logic [15:0] presc;
  logic        tick;

  logic [15:0] lfsr;
  logic        lfsr_fb;

  logic [11:0] delay;

  logic [3:0][3:0] dig;
  logic [3:0][3:0] dig_n;
  logic [3:0][3:0] dig_inc;
  logic            carry;
  logic            cnt_max;

  logic enter_wait;
  logic enter_go;
  logic enter_foul;
  logic sat_hit;

  logic led_go_n;
  logic foul_n;
  logic timeout_n;
  logic busy_n;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;

  assign tick = (presc == TICK_LAST);

  assign lfsr_fb = lfsr[15] ^ lfsr[13]
                 ^ lfsr[12] ^ lfsr[10];

  assign cnt_max = (dig == 16'h9999);

  assign enter_wait = (state != S_WAIT)
                    & (state_n == S_WAIT);
  assign enter_go   = (state == S_WAIT)
                    & (state_n == S_GO);
  assign enter_foul = (state != S_FOUL)
                    & (state_n == S_FOUL);

  // Saturation only counts when stop did not win.
  assign sat_hit = (state == S_GO)
                 & ~stop_rise
                 & tick
                 & cnt_max;

  assign bcd3 = dig[3];
  assign bcd2 = dig[2];
  assign bcd1 = dig[1];
  assign bcd0 = dig[0];

  // Button history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
    end
  end

  // Free-running LFSR, stepped every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Millisecond prescaler, re-phased on WAIT/GO entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (enter_wait | enter_go | tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Hold-off counter: loaded on WAIT entry, ticks down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay <= '0;
    end else if (enter_wait) begin
      delay <= DLY_BASE + {1'b0, lfsr[10:0]};
    end else if ((state == S_WAIT) && tick) begin
      delay <= delay - 12'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; stop wins in WAIT/GO.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start_rise) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_rise) begin
          state_n = S_FOUL;
        end else if (tick && (delay == 12'd1)) begin
          state_n = S_GO;
        end
      end
      S_GO: begin
        if (stop_rise) begin
          state_n = S_DONE;
        end else if (tick && cnt_max) begin
          state_n = S_DONE;
        end
      end
      S_DONE, S_FOUL: begin
        if (start_rise) begin
          state_n = S_WAIT;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Decimal increment with ripple carry.
  always_comb begin
    dig_inc = dig;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig[i] == 4'd9) begin
          dig_inc[i] = 4'd0;
        end else begin
          dig_inc[i] = dig[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    dig_n     = dig;
    led_go_n  = (state_n == S_GO);
    foul_n    = (state_n == S_FOUL);
    busy_n    = (state_n == S_WAIT)
              | (state_n == S_GO);
    timeout_n = 1'b0;

    unique case (1'b1)
      enter_wait: begin
        dig_n = '0;
      end
      enter_foul: begin
        dig_n = {4{4'hE}};
      end
      (state == S_GO) && (state_n == S_GO) && tick: begin
        dig_n = dig_inc;
      end
      default: begin
      end
    endcase

    if (state_n == S_DONE) begin
      timeout_n = sat_hit
                | ((state == S_DONE) & timeout);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig     <= '0;
      led_go  <= 1'b0;
      foul    <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
    end else begin
      dig     <= dig_n;
      led_go  <= led_go_n;
      foul    <= foul_n;
      timeout <= timeout_n;
      busy    <= busy_n;
    end
  end

endmodule
